// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// access sizes, grant identities and the IO region tag.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  typedef enum logic {GNT_IF, GNT_LS} grant_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] IO_HI_REGION = 2'b11;

  // The illegal size 2'b11 is served as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin arbiter between instruction fetch and load/store.
// Grants only while enabled; remembers the last winner for tie-breaking.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,
  input  logic if_elig,
  input  logic ls_elig,
  output logic grant_if,
  output logic grant_ls
);

  grant_t last_grant;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_if = en && if_elig && (!ls_elig || last_grant == GNT_LS);
    grant_ls = en && ls_elig && (!if_elig || last_grant == GNT_IF);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= GNT_IF;
    end else if (grant_if) begin
      last_grant <= GNT_IF;
    end else if (grant_ls) begin
      last_grant <= GNT_LS;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory port sequencer shared by fetch and load/store.
// Splits word/half/byte requests into byte cycles and reassembles read data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = IO_HI_REGION
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_size,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
);

  state_t            state_q, state_n;
  logic [2:0]        cnt_q, cnt_n;
  logic [31:0]       buf_q, buf_n;
  logic [ADDR_W-1:0] mem_a_n;
  logic [7:0]        mem_dout_n;
  logic              mem_wr_n;
  logic              if_done_q, if_done_n;
  logic              ls_done_q, ls_done_n;
  logic [31:0]       if_data_n, ls_rdata_n;
  logic              io_blocked, if_elig, ls_elig, grant_if, grant_ls;
  logic [2:0]        n_bytes;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        rd_idx;

  // A store into the IO region waits while the IO buffer is full.
  assign io_blocked = ls_we && (ls_addr[17:16] == IO_HI) && io_buffer_full;
  assign if_elig    = if_req && !if_flush && !if_done_q;
  assign ls_elig    = ls_req && !ls_done_q && !io_blocked;

  // Done registers hold across a freeze, so mask them until rdy_in returns.
  assign if_done    = if_done_q && rdy_in;
  assign ls_done    = ls_done_q && rdy_in;

  assign n_bytes    = (state_q == IF_RD) ? 3'd4 : size_bytes(ls_size);
  assign base_addr  = (state_q == IF_RD) ? if_addr : ls_addr;
  assign rd_idx     = 2'(cnt_q - 3'd2);

  mem_ctrl_arb u_arb (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in && state_q == IDLE),
    .if_elig  (if_elig),
    .ls_elig  (ls_elig),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // cnt_q counts edges since accept: it drives the next address, selects the
  // byte lane two edges behind it, and ends the access.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    buf_n      = buf_q;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = 1'b0;
    if_done_n  = 1'b0;
    ls_done_n  = 1'b0;
    if_data_n  = if_data;
    ls_rdata_n = ls_rdata;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_n = IF_RD;
          cnt_n   = 3'd1;
          buf_n   = '0;
          mem_a_n = if_addr;
        end else if (grant_ls) begin
          cnt_n   = 3'd1;
          buf_n   = '0;
          mem_a_n = ls_addr;
          if (ls_we) begin
            state_n    = LS_WR;
            mem_dout_n = ls_wdata[7:0];
            mem_wr_n   = 1'b1;
          end else begin
            state_n = LS_RD;
          end
        end
      end
      IF_RD, LS_RD: begin
        if (state_q == IF_RD && if_flush) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else begin
          if (cnt_q < n_bytes) begin
            mem_a_n = base_addr + ADDR_W'(cnt_q);
          end
          if (cnt_q >= 3'd2) begin
            buf_n[{rd_idx, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == 3'(n_bytes + 3'd1)) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            if (state_q == IF_RD) begin
              if_done_n = 1'b1;
              if_data_n = buf_n;
            end else begin
              ls_done_n  = 1'b1;
              ls_rdata_n = buf_n;
            end
          end else begin
            cnt_n = cnt_q + 3'd1;
          end
        end
      end
      LS_WR: begin
        if (cnt_q < n_bytes) begin
          mem_a_n    = ls_addr + ADDR_W'(cnt_q);
          mem_dout_n = ls_wdata[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_n   = 1'b1;
          cnt_n      = cnt_q + 3'd1;
        end else begin
          state_n   = IDLE;
          cnt_n     = 3'd0;
          ls_done_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      buf_q     <= '0;
      mem_a     <= '0;
      mem_dout  <= 8'd0;
      mem_wr    <= 1'b0;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      if_data   <= '0;
      ls_rdata  <= '0;
    end else if (rdy_in) begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      buf_q     <= buf_n;
      mem_a     <= mem_a_n;
      mem_dout  <= mem_dout_n;
      mem_wr    <= mem_wr_n;
      if_done_q <= if_done_n;
      ls_done_q <= ls_done_n;
      if_data   <= if_data_n;
      ls_rdata  <= ls_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model answers the port, expected
// results are queued at request time and popped when a done pulse appears.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_done;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_size;

  typedef struct packed {logic is_if; logic [31:0] data;} exp_t;
  typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;

  exp_t sb[$];
  wr_t  wr_obs[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] ram [0:262143];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  // Synchronous RAM: read data appears one cycle after the address; frozen with the core.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end
  end

  always @(negedge clk_in) begin
    if (mem_wr && rdy_in && !rst_in) wr_obs.push_back({mem_a, mem_dout});
  end

  // Waits for either done pulse, retires that requester; kind 0 means timeout.
  task automatic wait_any_done(input int budget, output int kind,
                               output logic [31:0] data, output int cycles);
    kind = 0; data = '0; cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      cycles++;
      if (if_done === 1'b1) begin
        kind = 1; data = if_data; if_req = 1'b0; return;
      end
      if (ls_done === 1'b1) begin
        kind = 2; data = ls_rdata; ls_req = 1'b0; return;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 2'b00; ls_wdata = '0;
    repeat (2) @(negedge clk_in);
    vectors++; if (mem_a !== 32'h0)    begin miscompares++; $display("[TB] FAIL reset_mem_a: got %h expected %h", mem_a, 32'h0); end
    vectors++; if (mem_dout !== 8'h0)  begin miscompares++; $display("[TB] FAIL reset_mem_dout: got %h expected %h", mem_dout, 8'h0); end
    vectors++; if (mem_wr !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    vectors++; if (if_done !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_if_done: got %b expected 0", if_done); end
    vectors++; if (if_data !== 32'h0)  begin miscompares++; $display("[TB] FAIL reset_if_data: got %h expected %h", if_data, 32'h0); end
    vectors++; if (ls_done !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_ls_done: got %b expected 0", ls_done); end
    vectors++; if (ls_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ls_rdata: got %h expected %h", ls_rdata, 32'h0); end
    rst_in = 1'b0;
  endtask

  task automatic test_fetch();
    int kind, cyc; logic [31:0] data; exp_t e;
    @(negedge clk_in);
    wr_obs.delete();
    if_addr = 32'h100; if_req = 1'b1;
    sb.push_back(exp_t'({1'b1, 32'h00100513}));
    wait_any_done(20, kind, data, cyc);
    e = sb.pop_front();
    vectors++; if (kind != 1)        begin miscompares++; $display("[TB] FAIL fetch_kind: got %0d expected 1", kind); end
    vectors++; if (data !== e.data)  begin miscompares++; $display("[TB] FAIL fetch_data: got %h expected %h", data, e.data); end
    vectors++; if (cyc != 6)         begin miscompares++; $display("[TB] FAIL fetch_latency: got %0d expected 6", cyc); end
    vectors++; if (wr_obs.size() != 0) begin miscompares++; $display("[TB] FAIL fetch_no_write: got %0d writes expected 0", wr_obs.size()); end
    @(negedge clk_in);
    vectors++; if (if_done !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_pulse_width: got %b expected 0", if_done); end
  endtask

  task automatic test_store();
    int kind, cyc; logic [31:0] data;
    wr_t exp_wr[4];
    exp_wr[0] = {32'h2000, 8'hEF}; exp_wr[1] = {32'h2001, 8'hBE};
    exp_wr[2] = {32'h2002, 8'hAD}; exp_wr[3] = {32'h2003, 8'hDE};
    @(negedge clk_in);
    wr_obs.delete();
    ls_we = 1'b1; ls_addr = 32'h2000; ls_size = 2'b10; ls_wdata = 32'hDEADBEEF; ls_req = 1'b1;
    wait_any_done(20, kind, data, cyc);
    ls_we = 1'b0;
    vectors++; if (kind != 2) begin miscompares++; $display("[TB] FAIL store_kind: got %0d expected 2", kind); end
    vectors++; if (cyc != 5)  begin miscompares++; $display("[TB] FAIL store_latency: got %0d expected 5", cyc); end
    vectors++; if (wr_obs.size() != 4) begin miscompares++; $display("[TB] FAIL store_count: got %0d expected 4", wr_obs.size()); end
    for (int i = 0; i < 4 && i < wr_obs.size(); i++) begin
      vectors++;
      if (wr_obs[i] !== exp_wr[i]) begin
        miscompares++;
        $display("[TB] FAIL store_byte%0d: got a=%h d=%h expected a=%h d=%h", i, wr_obs[i].a, wr_obs[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
  endtask

  task automatic test_contention();
    int kind, cyc; logic [31:0] data; exp_t e;
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0;
    // Round 1: last winner is IF after reset, so LS goes first.
    if_addr = 32'h100; if_req = 1'b1;
    ls_we = 1'b0; ls_addr = 32'h10; ls_size = 2'b01; ls_req = 1'b1;
    sb.push_back(exp_t'({1'b0, 32'h00001234}));
    sb.push_back(exp_t'({1'b1, 32'h00100513}));
    for (int r = 0; r < 2; r++) begin
      wait_any_done(30, kind, data, cyc);
      e = sb.pop_front();
      vectors++; if (kind != (e.is_if ? 1 : 2)) begin miscompares++; $display("[TB] FAIL rr1_order%0d: got %0d expected %0d", r, kind, e.is_if ? 1 : 2); end
      vectors++; if (data !== e.data) begin miscompares++; $display("[TB] FAIL rr1_data%0d: got %h expected %h", r, data, e.data); end
      if (r == 1) begin
        vectors++; if (cyc != 6) begin miscompares++; $display("[TB] FAIL back_to_back_latency: got %0d expected 6", cyc); end
      end
    end
    // Round 2: a lone LS win makes IF the tie-break winner next.
    @(negedge clk_in);
    ls_addr = 32'h12; ls_size = 2'b00; ls_req = 1'b1;
    sb.push_back(exp_t'({1'b0, 32'h000000FF}));
    wait_any_done(20, kind, data, cyc);
    e = sb.pop_front();
    vectors++; if (kind != 2 || data !== e.data) begin miscompares++; $display("[TB] FAIL lone_ls: got kind %0d data %h expected kind 2 data %h", kind, data, e.data); end
    @(negedge clk_in);
    if_addr = 32'h200; if_req = 1'b1;
    ls_addr = 32'h10; ls_size = 2'b01; ls_req = 1'b1;
    sb.push_back(exp_t'({1'b1, 32'h00100093}));
    sb.push_back(exp_t'({1'b0, 32'h00001234}));
    for (int r = 0; r < 2; r++) begin
      wait_any_done(30, kind, data, cyc);
      e = sb.pop_front();
      vectors++; if (kind != (e.is_if ? 1 : 2)) begin miscompares++; $display("[TB] FAIL rr2_order%0d: got %0d expected %0d", r, kind, e.is_if ? 1 : 2); end
      vectors++; if (data !== e.data) begin miscompares++; $display("[TB] FAIL rr2_data%0d: got %h expected %h", r, data, e.data); end
    end
  endtask

  task automatic test_flush();
    int kind, cyc; logic [31:0] data; exp_t e; logic seen;
    seen = 1'b0;
    @(negedge clk_in);
    if_addr = 32'h100; if_req = 1'b1;
    repeat (2) begin @(negedge clk_in); seen |= if_done; end
    if_flush = 1'b1;
    @(negedge clk_in); seen |= if_done; if_addr = 32'h200;
    @(negedge clk_in); seen |= if_done; if_flush = 1'b0;
    sb.push_back(exp_t'({1'b1, 32'h00100093}));
    wait_any_done(20, kind, data, cyc);
    e = sb.pop_front();
    vectors++; if (seen !== 1'b0)   begin miscompares++; $display("[TB] FAIL flush_no_done: got %b expected 0", seen); end
    vectors++; if (kind != 1)       begin miscompares++; $display("[TB] FAIL flush_refetch_kind: got %0d expected 1", kind); end
    vectors++; if (data !== e.data) begin miscompares++; $display("[TB] FAIL flush_refetch_data: got %h expected %h", data, e.data); end
    vectors++; if (cyc != 6)        begin miscompares++; $display("[TB] FAIL flush_refetch_latency: got %0d expected 6", cyc); end
  endtask

  task automatic test_io_gating();
    int kind, cyc; logic [31:0] data; exp_t e;
    @(negedge clk_in);
    wr_obs.delete();
    io_buffer_full = 1'b1;
    ls_we = 1'b1; ls_addr = 32'h30000; ls_size = 2'b00; ls_wdata = 32'h5A5A5AA5; ls_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    sb.push_back(exp_t'({1'b1, 32'h00100513}));
    wait_any_done(20, kind, data, cyc);
    e = sb.pop_front();
    io_buffer_full = 1'b0;
    vectors++; if (kind != 1 || data !== e.data) begin miscompares++; $display("[TB] FAIL io_fetch_first: got kind %0d data %h expected kind 1 data %h", kind, data, e.data); end
    vectors++; if (cyc != 6) begin miscompares++; $display("[TB] FAIL io_fetch_latency: got %0d expected 6", cyc); end
    vectors++; if (wr_obs.size() != 0) begin miscompares++; $display("[TB] FAIL io_store_held: got %0d writes expected 0", wr_obs.size()); end
    wait_any_done(10, kind, data, cyc);
    ls_we = 1'b0;
    vectors++; if (kind != 2) begin miscompares++; $display("[TB] FAIL io_store_kind: got %0d expected 2", kind); end
    vectors++; if (cyc != 2)  begin miscompares++; $display("[TB] FAIL io_store_latency: got %0d expected 2", cyc); end
    vectors++;
    if (wr_obs.size() != 1 || wr_obs[0] !== wr_t'({32'h30000, 8'hA5})) begin
      miscompares++;
      $display("[TB] FAIL io_store_write: got %0d writes first=%h expected 1 write %h", wr_obs.size(),
               (wr_obs.size() > 0) ? wr_obs[0] : wr_t'(0), wr_t'({32'h30000, 8'hA5}));
    end
  endtask

  task automatic test_freeze();
    int kind, cyc; logic [31:0] data; exp_t e; logic seen;
    seen = 1'b0;
    @(negedge clk_in);
    ls_we = 1'b0; ls_addr = 32'h100; ls_size = 2'b10; ls_req = 1'b1;
    sb.push_back(exp_t'({1'b0, 32'h00100513}));
    repeat (2) begin @(negedge clk_in); seen |= ls_done; end
    rdy_in = 1'b0;
    repeat (3) begin @(negedge clk_in); seen |= ls_done; end
    rdy_in = 1'b1;
    wait_any_done(20, kind, data, cyc);
    e = sb.pop_front();
    vectors++; if (seen !== 1'b0)   begin miscompares++; $display("[TB] FAIL freeze_early_done: got %b expected 0", seen); end
    vectors++; if (kind != 2)       begin miscompares++; $display("[TB] FAIL freeze_kind: got %0d expected 2", kind); end
    vectors++; if (data !== e.data) begin miscompares++; $display("[TB] FAIL freeze_data: got %h expected %h", data, e.data); end
    vectors++; if (cyc != 4)        begin miscompares++; $display("[TB] FAIL freeze_latency: got %0d expected 4", cyc); end
  endtask

  task automatic test_async_reset();
    int kind, cyc; logic [31:0] data; exp_t e;
    @(negedge clk_in);
    ls_we = 1'b1; ls_addr = 32'h2000; ls_size = 2'b10; ls_wdata = 32'h11223344; ls_req = 1'b1;
    repeat (2) @(negedge clk_in);
    vectors++; if (mem_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_write_active: got %b expected 1", mem_wr); end
    #2 rst_in = 1'b1; ls_req = 1'b0; ls_we = 1'b0;
    #1;
    vectors++; if (mem_wr !== 1'b0)  begin miscompares++; $display("[TB] FAIL arst_mem_wr: got %b expected 0", mem_wr); end
    vectors++; if (mem_a !== 32'h0)  begin miscompares++; $display("[TB] FAIL arst_mem_a: got %h expected %h", mem_a, 32'h0); end
    @(negedge clk_in);
    rst_in = 1'b0;
    wr_obs.delete();
    if_addr = 32'h100; if_req = 1'b1;
    sb.push_back(exp_t'({1'b1, 32'h00100513}));
    wait_any_done(20, kind, data, cyc);
    e = sb.pop_front();
    vectors++; if (kind != 1 || data !== e.data) begin miscompares++; $display("[TB] FAIL arst_refetch: got kind %0d data %h expected kind 1 data %h", kind, data, e.data); end
    vectors++; if (cyc != 6) begin miscompares++; $display("[TB] FAIL arst_idle_latency: got %0d expected 6", cyc); end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;
    ram[32'h10]  = 8'h34; ram[32'h11]  = 8'h12; ram[32'h12]  = 8'hFF;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_flush();
    test_io_gating();
    test_freeze();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
